// File: rtl/sid_host_write_arbiter_if.sv
// Bus bundle around the SID register-write arbiter.
// Carries the voice_cycle rotation, the synchronized CPU bus, the host
// write port and the merged bus that feeds sid_control.
//   slave  : arbiter side (consumes CPU/host, drives out_*/status)
//   master : environment side (drives CPU/host, observes out_*/status)
interface sid_host_write_arbiter_if #(
    parameter int unsigned CYCLE_W = 4
);
    // Voice pipeline rotation
    logic [CYCLE_W-1:0] voice_cycle;

    // Synchronized MOS6510 bus
    logic               cpu_phi2;
    logic               cpu_r_w_n;
    logic [4:0]         cpu_addr;
    logic [7:0]         cpu_data;
    logic [1:0]         cpu_cs;

    // Host write port
    logic               host_valid;
    logic               host_ready;
    logic               host_sid;
    logic [4:0]         host_addr;
    logic [7:0]         host_data;
    logic               host_err;

    // Merged bus towards sid_control
    logic               out_phi2;
    logic               out_r_w_n;
    logic [4:0]         out_addr;
    logic [7:0]         out_data;
    logic [1:0]         out_cs;

    // Status
    logic               host_slot;
    logic [7:0]         collisions;

    modport slave (
        input  voice_cycle,
        input  cpu_phi2, cpu_r_w_n, cpu_addr, cpu_data, cpu_cs,
        input  host_valid, host_sid, host_addr, host_data,
        output host_ready, host_err,
        output out_phi2, out_r_w_n, out_addr, out_data, out_cs,
        output host_slot, collisions
    );

    modport master (
        output voice_cycle,
        output cpu_phi2, cpu_r_w_n, cpu_addr, cpu_data, cpu_cs,
        output host_valid, host_sid, host_addr, host_data,
        input  host_ready, host_err,
        input  out_phi2, out_r_w_n, out_addr, out_data, out_cs,
        input  host_slot, collisions
    );
endinterface

// File: rtl/sid_host_write_arbiter.sv
// Shares the SID register-write path between the CPU bus and a host port.
// Host writes are queued in a DEPTH-entry FIFO and injected as synthetic
// write slots that span one full voice_cycle rotation. Any CPU chip-select
// aborts the slot in the same cycle; the entry stays queued and is retried.
// Ports:
//   clk  - system clock
//   res  - synchronous active-high reset
//   bus  - sid_host_write_arbiter_if.slave (voice_cycle, cpu_*, host_*,
//          out_*, host_slot, collisions)
module sid_host_write_arbiter #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CYCLE_W = 4
) (
    input  logic                         clk,
    input  logic                         res,
    sid_host_write_arbiter_if.slave      bus
);

    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
    localparam int unsigned LAST_REG  = 12;
    localparam logic [4:0]  ADDR_MAX  = 5'h18;
    localparam logic [7:0]  COLL_MAX  = 8'hFF;

    typedef struct packed {
        logic       sid;
        logic [4:0] addr;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLOT  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    // Storage and bookkeeping
    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               ready_q;
    logic               err_q;
    logic [7:0]         coll_q;

    state_t             state_q;
    state_t             state_d;
    entry_t             slot_q;
    logic               seen_rot_q;
    logic               armed_q;

    // Decoded conditions
    logic               vc_zero;
    logic               vc_rot;
    logic               cpu_busy;
    logic               fifo_empty;
    logic               addr_ok;
    logic               push;
    logic               reject;
    logic               grant;
    logic               pop;
    logic               abort;
    logic               leave;
    logic               drive_slot;

    assign vc_zero    = (bus.voice_cycle == '0);
    assign vc_rot     = !vc_zero && (bus.voice_cycle <= CYCLE_W'(LAST_REG));
    assign cpu_busy   = (bus.cpu_cs != 2'b00);
    assign fifo_empty = (count_q == '0);
    assign addr_ok    = (bus.host_addr <= ADDR_MAX);
    assign push       = bus.host_valid && ready_q && addr_ok;
    assign reject     = bus.host_valid && ready_q && !addr_ok;

    // Next-state and slot control
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        pop     = 1'b0;
        abort   = 1'b0;
        leave   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vc_zero && armed_q && !fifo_empty && !cpu_busy) begin
                    grant   = 1'b1;
                    state_d = ST_SLOT;
                end
            end
            ST_SLOT: begin
                // abort wins over a completion landing in the same cycle
                if (cpu_busy) begin
                    abort   = 1'b1;
                    state_d = ST_ABORT;
                end else if (vc_zero && seen_rot_q) begin
                    pop     = 1'b1;
                    leave   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                if (!cpu_busy && vc_zero) begin
                    leave   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State register and slot tracking
    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= ST_IDLE;
            seen_rot_q <= 1'b0;
            armed_q    <= 1'b1;
            slot_q     <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                slot_q     <= mem[rd_ptr_q];
                seen_rot_q <= 1'b0;
            end else if (state_q == ST_SLOT && vc_rot) begin
                seen_rot_q <= 1'b1;
            end
            // After a slot ends, wait for the rotation to move off 0 so the
            // next grant lands on a fresh slot boundary.
            if (leave) begin
                armed_q <= 1'b0;
            end else if (!vc_zero) begin
                armed_q <= 1'b1;
            end
        end
    end

    // FIFO pointers, occupancy, ready and error pulse
    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d < CNT_W'(DEPTH));
            err_q   <= reject;
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= '{sid: bus.host_sid, addr: bus.host_addr, data: bus.host_data};
        end
    end

    // Saturating abort counter
    always_ff @(posedge clk) begin
        if (res) begin
            coll_q <= '0;
        end else if (abort && coll_q != COLL_MAX) begin
            coll_q <= coll_q + 8'd1;
        end
    end

    // Output mux: CPU chip-select forces pass-through within the same cycle
    assign drive_slot = (state_q == ST_SLOT) && !cpu_busy;

    always_comb begin
        bus.out_phi2  = bus.cpu_phi2;
        bus.out_r_w_n = bus.cpu_r_w_n;
        bus.out_addr  = bus.cpu_addr;
        bus.out_data  = bus.cpu_data;
        bus.out_cs    = bus.cpu_cs;
        if (drive_slot) begin
            bus.out_phi2  = 1'b0;
            bus.out_r_w_n = 1'b0;
            bus.out_addr  = slot_q.addr;
            bus.out_data  = slot_q.data;
            bus.out_cs    = slot_q.sid ? 2'b10 : 2'b01;
        end
    end

    assign bus.host_slot  = drive_slot;
    assign bus.host_ready = ready_q;
    assign bus.host_err   = err_q;
    assign bus.collisions = coll_q;

endmodule
